// File: rtl/translator_pkg.sv
// Shared constants and the colour-stripping address translation for the AXI colour translator.
package translator_pkg;

    // AxLEN(8) + AxSIZE(3) + AxBURST(2) + AxLOCK(1) + AxCACHE(4) + AxPROT(3) + AxQOS(4)
    localparam int AX_SIDE_W = 25;
    localparam int MAX_OUTSTANDING_DFLT = 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING_DFLT + 1);

    function automatic int ax_payload_w(input int id_w, input int addr_w);
        return id_w + addr_w + AX_SIDE_W;
    endfunction

    // Drop addr[ub:lb], close the gap, keep only the low kw input bits, then relocate into base.
    function automatic logic [63:0] translate_addr(input logic [63:0] addr, input int ub,
                                                   input int lb, input int kw,
                                                   input logic [63:0] base);
        logic [63:0] res;
        int          cw;
        int          src;
        res = '0;
        cw  = ub - lb + 1;
        for (int i = 0; i < 64; i++) begin
            src = i + cw;
            if (i < lb) begin
                res[i[5:0]] = addr[i[5:0]];
            end else if (src < kw) begin
                res[i[5:0]] = addr[src[5:0]];
            end
        end
        return res | base;
    endfunction

endpackage

// File: rtl/axi_skid_slice.sv
// Full-throughput two-entry register slice with a registered upstream ready.
module axi_skid_slice
    import translator_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 block_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [PAYLOAD_W-1:0] s_payload_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [PAYLOAD_W-1:0] m_payload_o
);

    logic                 main_vld_q, main_vld_d;
    logic                 skid_vld_q, skid_vld_d;
    logic                 rdy_q, rdy_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 s_hs;

    assign s_hs        = s_valid_i & rdy_q;
    assign s_ready_o   = rdy_q;
    assign m_valid_o   = main_vld_q;
    assign m_payload_o = main_q;

    always_comb begin
        main_vld_d = main_vld_q;
        main_d     = main_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (!main_vld_q || m_ready_i) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = s_hs;
                main_d     = s_payload_i;
            end
        end else if (s_hs) begin
            // main is stalled: the beat accepted under the registered ready lands in skid
            skid_vld_d = 1'b1;
            skid_d     = s_payload_i;
        end
        rdy_d = !skid_vld_d && !block_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/axi_color_translator_slice.sv
// Registered AXI4 colour-stripping address translator with per-direction outstanding limits.
module axi_color_translator_slice
    import translator_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH         = 1,
    parameter int C_AXI_ADDR_WIDTH       = 40,
    parameter int C_AXI_DATA_WIDTH       = 128,
    parameter int COLOR_BITS_UPPER_BOUND = 15,
    parameter int COLOR_BITS_LOWER_BOUND = 14,
    parameter int ADDR_KEEP_WIDTH        = 32,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] C_M00_AXI_TARGET_SLAVE_BASE_ADDR = 40'h40_0000_0000,
    parameter int MAX_OUTSTANDING        = MAX_OUTSTANDING_DFLT
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_AXI_ID_WIDTH-1:0]       s00_axi_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [7:0]                      s00_axi_awlen,
    input  logic [2:0]                      s00_axi_awsize,
    input  logic [1:0]                      s00_axi_awburst,
    input  logic                            s00_axi_awlock,
    input  logic [3:0]                      s00_axi_awcache,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic [3:0]                      s00_axi_awqos,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                            s00_axi_wlast,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [C_AXI_ID_WIDTH-1:0]       s00_axi_bid,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_AXI_ID_WIDTH-1:0]       s00_axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [7:0]                      s00_axi_arlen,
    input  logic [2:0]                      s00_axi_arsize,
    input  logic [1:0]                      s00_axi_arburst,
    input  logic                            s00_axi_arlock,
    input  logic [3:0]                      s00_axi_arcache,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic [3:0]                      s00_axi_arqos,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_AXI_ID_WIDTH-1:0]       s00_axi_rid,
    output logic [C_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rlast,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_AXI_ID_WIDTH-1:0]       m00_axi_awid,
    output logic [C_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [7:0]                      m00_axi_awlen,
    output logic [2:0]                      m00_axi_awsize,
    output logic [1:0]                      m00_axi_awburst,
    output logic                            m00_axi_awlock,
    output logic [3:0]                      m00_axi_awcache,
    output logic [2:0]                      m00_axi_awprot,
    output logic [3:0]                      m00_axi_awqos,
    output logic                            m00_axi_awvalid,
    input  logic                            m00_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                            m00_axi_wlast,
    output logic                            m00_axi_wvalid,
    input  logic                            m00_axi_wready,
    input  logic [C_AXI_ID_WIDTH-1:0]       m00_axi_bid,
    input  logic [1:0]                      m00_axi_bresp,
    input  logic                            m00_axi_bvalid,
    output logic                            m00_axi_bready,
    output logic [C_AXI_ID_WIDTH-1:0]       m00_axi_arid,
    output logic [C_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [7:0]                      m00_axi_arlen,
    output logic [2:0]                      m00_axi_arsize,
    output logic [1:0]                      m00_axi_arburst,
    output logic                            m00_axi_arlock,
    output logic [3:0]                      m00_axi_arcache,
    output logic [2:0]                      m00_axi_arprot,
    output logic [3:0]                      m00_axi_arqos,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_AXI_ID_WIDTH-1:0]       m00_axi_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rlast,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int PAY_W     = ax_payload_w(C_AXI_ID_WIDTH, C_AXI_ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [63:0]          BASE64  = 64'(C_M00_AXI_TARGET_SLAVE_BASE_ADDR);

    function automatic logic [CNT_WIDTH-1:0] step_count(input logic [CNT_WIDTH-1:0] cnt,
                                                         input logic inc, input logic dec);
        if (inc && !dec) return cnt + 1'b1;
        if (dec && !inc && cnt != '0) return cnt - 1'b1;
        return cnt;
    endfunction

    logic [C_AXI_ADDR_WIDTH-1:0] aw_addr_xl, ar_addr_xl;
    logic [PAY_W-1:0]            aw_pay_in, aw_pay_out, ar_pay_in, ar_pay_out;
    logic [CNT_WIDTH-1:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                        aw_hs, ar_hs, b_done, r_done, wr_block, rd_block;

    assign aw_addr_xl = C_AXI_ADDR_WIDTH'(translate_addr(64'(s00_axi_awaddr), COLOR_BITS_UPPER_BOUND,
                            COLOR_BITS_LOWER_BOUND, ADDR_KEEP_WIDTH, BASE64));
    assign ar_addr_xl = C_AXI_ADDR_WIDTH'(translate_addr(64'(s00_axi_araddr), COLOR_BITS_UPPER_BOUND,
                            COLOR_BITS_LOWER_BOUND, ADDR_KEEP_WIDTH, BASE64));

    assign aw_pay_in = {s00_axi_awid, aw_addr_xl, s00_axi_awlen, s00_axi_awsize, s00_axi_awburst,
                        s00_axi_awlock, s00_axi_awcache, s00_axi_awprot, s00_axi_awqos};
    assign ar_pay_in = {s00_axi_arid, ar_addr_xl, s00_axi_arlen, s00_axi_arsize, s00_axi_arburst,
                        s00_axi_arlock, s00_axi_arcache, s00_axi_arprot, s00_axi_arqos};

    assign {m00_axi_awid, m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst,
            m00_axi_awlock, m00_axi_awcache, m00_axi_awprot, m00_axi_awqos} = aw_pay_out;
    assign {m00_axi_arid, m00_axi_araddr, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst,
            m00_axi_arlock, m00_axi_arcache, m00_axi_arprot, m00_axi_arqos} = ar_pay_out;

    // A transaction opens on the slave address handshake and closes on B, or on the last R beat.
    assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
    assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
    assign b_done = m00_axi_bvalid & s00_axi_bready;
    assign r_done = m00_axi_rvalid & s00_axi_rready & m00_axi_rlast;

    always_comb begin
        wr_cnt_d = step_count(wr_cnt_q, aw_hs, b_done);
        rd_cnt_d = step_count(rd_cnt_q, ar_hs, r_done);
        wr_block = (wr_cnt_d == MAX_CNT);
        rd_block = (rd_cnt_d == MAX_CNT);
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_outstanding = wr_cnt_q;
    assign rd_outstanding = rd_cnt_q;

    axi_skid_slice #(.PAYLOAD_W(PAY_W)) u_aw_slice (
        .clk_i      (s00_axi_aclk),
        .rst_ni     (s00_axi_aresetn),
        .block_i    (wr_block),
        .s_valid_i  (s00_axi_awvalid),
        .s_ready_o  (s00_axi_awready),
        .s_payload_i(aw_pay_in),
        .m_valid_o  (m00_axi_awvalid),
        .m_ready_i  (m00_axi_awready),
        .m_payload_o(aw_pay_out)
    );

    axi_skid_slice #(.PAYLOAD_W(PAY_W)) u_ar_slice (
        .clk_i      (s00_axi_aclk),
        .rst_ni     (s00_axi_aresetn),
        .block_i    (rd_block),
        .s_valid_i  (s00_axi_arvalid),
        .s_ready_o  (s00_axi_arready),
        .s_payload_i(ar_pay_in),
        .m_valid_o  (m00_axi_arvalid),
        .m_ready_i  (m00_axi_arready),
        .m_payload_o(ar_pay_out)
    );

    assign m00_axi_wdata  = s00_axi_wdata;
    assign m00_axi_wstrb  = s00_axi_wstrb;
    assign m00_axi_wlast  = s00_axi_wlast;
    assign m00_axi_wvalid = s00_axi_wvalid;
    assign s00_axi_wready = m00_axi_wready;

    assign s00_axi_bid    = m00_axi_bid;
    assign s00_axi_bresp  = m00_axi_bresp;
    assign s00_axi_bvalid = m00_axi_bvalid;
    assign m00_axi_bready = s00_axi_bready;

    assign s00_axi_rid    = m00_axi_rid;
    assign s00_axi_rdata  = m00_axi_rdata;
    assign s00_axi_rresp  = m00_axi_rresp;
    assign s00_axi_rlast  = m00_axi_rlast;
    assign s00_axi_rvalid = m00_axi_rvalid;
    assign m00_axi_rready = s00_axi_rready;

endmodule
